// File: rtl/tblink_rpc_pktarb.sv
// tblink_rpc_pktarb: packet-level round-robin arbiter sharing one byte stream among N_PORTS requesters
module tblink_rpc_pktarb #(
  parameter int N_PORTS = 4,
  parameter int CNT_W = 16
) (
  input  logic                   uclock,
  input  logic                   reset,
  input  logic [8*N_PORTS-1:0]   i_dat,
  input  logic [N_PORTS-1:0]     i_valid,
  output logic [N_PORTS-1:0]     i_ready,
  input  logic [N_PORTS-1:0]     en_mask,
  output logic [7:0]             o_dat,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic                   o_last,
  output logic [N_PORTS-1:0]     grant,
  output logic                   busy,
  output logic [CNT_W-1:0]       pkt_count
);
  localparam int IW = $clog2(N_PORTS);
  typedef enum logic [1:0] {IDLE, HDR, LEN, PAY} state_t;
  state_t state, state_n;
  logic [IW-1:0] last_grant, lg_n, sel, cand;
  logic [N_PORTS-1:0] grant_n, elig;
  logic [7:0] rem, rem_n;
  logic [CNT_W-1:0] cnt_n;
  logic found, xfer, last_cond, done;
  assign elig = i_valid & en_mask;
  assign busy = state != IDLE;
  assign o_dat = busy ? i_dat[8*last_grant +: 8] : 8'h00;
  assign o_valid = busy & i_valid[last_grant];
  assign i_ready = grant & {N_PORTS{o_ready}};
  assign xfer = o_valid & o_ready;
  assign last_cond = (state == LEN && o_dat == 8'h00) || (state == PAY && rem == 8'd1);
  assign o_last = o_valid & last_cond;
  assign done = o_last & o_ready;
  // Scanning downward lets the nearest port after last_grant overwrite farther ones.
  always_comb begin
    found = 1'b0;
    sel = last_grant;
    cand = '0;
    for (int i = N_PORTS; i >= 1; i--) begin
      cand = IW'((int'(last_grant) + i) % N_PORTS);
      if (elig[cand]) begin
        found = 1'b1;
        sel = cand;
      end
    end
  end
  always_comb begin
    state_n = state;
    grant_n = grant;
    lg_n = last_grant;
    rem_n = rem;
    cnt_n = pkt_count;
    case (state)
      IDLE: if (found) begin
        state_n = HDR;
        grant_n = N_PORTS'(1) << sel;
        lg_n = sel;
      end
      HDR: if (xfer) state_n = LEN;
      LEN: if (xfer) begin
        rem_n = o_dat;
        state_n = PAY;
      end
      PAY: if (xfer) rem_n = rem - 8'd1;
      default: state_n = IDLE;
    endcase
    if (done) begin
      state_n = IDLE;
      grant_n = '0;
      cnt_n = pkt_count + 1'b1;
    end
  end
  always_ff @(posedge uclock) begin
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= IW'(N_PORTS - 1);
      rem <= '0;
      pkt_count <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      last_grant <= lg_n;
      rem <= rem_n;
      pkt_count <= cnt_n;
    end
  end
endmodule
